// File: rtl/cmul_pkg.sv
// cmul_pkg: shared widths and operand/result types for the complex-multiply
// scheduler and its pipelined multiplier.
//   OP_W     - width of each signed operand component
//   PROD_W   - width of each signed product and of each result component
//   PIPE_LAT - edges from operand acceptance to result presentation
package cmul_pkg;

  localparam int OP_W     = 16;
  localparam int PROD_W   = 32;
  localparam int PIPE_LAT = 2;

  typedef struct packed {
    logic signed [OP_W-1:0] ar;
    logic signed [OP_W-1:0] ai;
    logic signed [OP_W-1:0] br;
    logic signed [OP_W-1:0] bi;
  } cplx_op_t;

  typedef struct packed {
    logic signed [PROD_W-1:0] pr;
    logic signed [PROD_W-1:0] pi;
  } cplx_res_t;

  // Sign-extend an operand to product width so multiplies are full-width.
  function automatic logic signed [PROD_W-1:0] sext(input logic signed [OP_W-1:0] x);
    return {{(PROD_W-OP_W){x[OP_W-1]}}, x};
  endfunction

endpackage

// File: rtl/cmul_rr_sched_if.sv
// cmul_rr_sched_if: request/response bundle between NREQ DSP clients and
// the shared complex multiplier scheduler.
//   req_valid/req_ready            - per-requester handshake
//   req_ar/ai/br/bi                - packed signed operands, requester i at [16i+15:16i]
//   rsp_valid/rsp_id/rsp_pr/rsp_pi - tagged result, no backpressure
// Modports: master = requester side, slave = scheduler side.
interface cmul_rr_sched_if #(parameter int NREQ = 4);
  import cmul_pkg::*;

  localparam int ID_W = $clog2(NREQ);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [OP_W*NREQ-1:0]   req_ar;
  logic [OP_W*NREQ-1:0]   req_ai;
  logic [OP_W*NREQ-1:0]   req_br;
  logic [OP_W*NREQ-1:0]   req_bi;
  logic                   rsp_valid;
  logic [ID_W-1:0]        rsp_id;
  logic signed [PROD_W-1:0] rsp_pr;
  logic signed [PROD_W-1:0] rsp_pi;

  modport master (
    output req_valid, req_ar, req_ai, req_br, req_bi,
    input  req_ready, rsp_valid, rsp_id, rsp_pr, rsp_pi
  );

  modport slave (
    input  req_valid, req_ar, req_ai, req_br, req_bi,
    output req_ready, rsp_valid, rsp_id, rsp_pr, rsp_pi
  );

endinterface

// File: rtl/cmul_pipe.sv
// cmul_pipe: 2-stage pipelined 16x16 complex multiplier with valid+tag sideband.
//   clk, rst         - clock, synchronous active-high reset
//   in_valid/in_tag  - operand strobe and owner tag
//   in_op            - ar, ai, br, bi
//   out_valid/out_tag/out_res - result (pr = ar*br - ai*bi, pi = ar*bi + ai*br)
// Stage 0 registers the four products, stage 1 the wrapped sum/difference.
module cmul_pipe
  import cmul_pkg::*;
#(
  parameter int TAG_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  input  cplx_op_t         in_op,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag,
  output cplx_res_t        out_res
);

  logic                     s0_valid_q, s0_valid_d;
  logic [TAG_W-1:0]         s0_tag_q,   s0_tag_d;
  logic signed [PROD_W-1:0] s0_rr_q, s0_rr_d;
  logic signed [PROD_W-1:0] s0_ii_q, s0_ii_d;
  logic signed [PROD_W-1:0] s0_ri_q, s0_ri_d;
  logic signed [PROD_W-1:0] s0_ir_q, s0_ir_d;

  logic                     s1_valid_q, s1_valid_d;
  logic [TAG_W-1:0]         s1_tag_q,   s1_tag_d;
  cplx_res_t                s1_res_q,   s1_res_d;

  always_comb begin
    s0_valid_d = in_valid;
    s0_tag_d   = s0_tag_q;
    s0_rr_d    = s0_rr_q;
    s0_ii_d    = s0_ii_q;
    s0_ri_d    = s0_ri_q;
    s0_ir_d    = s0_ir_q;
    if (in_valid) begin
      s0_tag_d = in_tag;
      s0_rr_d  = sext(in_op.ar) * sext(in_op.br);
      s0_ii_d  = sext(in_op.ai) * sext(in_op.bi);
      s0_ri_d  = sext(in_op.ar) * sext(in_op.bi);
      s0_ir_d  = sext(in_op.ai) * sext(in_op.br);
    end

    // Outputs hold their last value on idle cycles.
    s1_valid_d = s0_valid_q;
    s1_tag_d   = s1_tag_q;
    s1_res_d   = s1_res_q;
    if (s0_valid_q) begin
      s1_tag_d    = s0_tag_q;
      s1_res_d.pr = s0_rr_q - s0_ii_q;
      s1_res_d.pi = s0_ri_q + s0_ir_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid_q <= 1'b0;
      s0_tag_q   <= '0;
      s0_rr_q    <= '0;
      s0_ii_q    <= '0;
      s0_ri_q    <= '0;
      s0_ir_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_tag_q   <= '0;
      s1_res_q   <= '0;
    end else begin
      s0_valid_q <= s0_valid_d;
      s0_tag_q   <= s0_tag_d;
      s0_rr_q    <= s0_rr_d;
      s0_ii_q    <= s0_ii_d;
      s0_ri_q    <= s0_ri_d;
      s0_ir_q    <= s0_ir_d;
      s1_valid_q <= s1_valid_d;
      s1_tag_q   <= s1_tag_d;
      s1_res_q   <= s1_res_d;
    end
  end

  assign out_valid = s1_valid_q;
  assign out_tag   = s1_tag_q;
  assign out_res   = s1_res_q;

endmodule

// File: rtl/cmul_rr_sched.sv
// cmul_rr_sched: round-robin scheduler (with optional burst lock) sharing one
// pipelined complex multiplier among NREQ requesters.
//   clk, rst - clock, synchronous active-high reset
//   bus      - slave side of cmul_rr_sched_if (request handshake/operands in,
//              tagged results out with fixed latency)
// Parameters: NREQ requesters (2..8), BURST max consecutive beats per grant.
module cmul_rr_sched
  import cmul_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int BURST = 1
) (
  input  logic           clk,
  input  logic           rst,
  cmul_rr_sched_if.slave bus
);

  localparam int          ID_W   = $clog2(NREQ);
  localparam int          BC_W   = $clog2(BURST + 1);
  localparam int unsigned NREQ_U = NREQ;

  logic [ID_W-1:0] ptr_q,      ptr_d;
  logic [ID_W-1:0] owner_q,    owner_d;
  logic            lock_q,     lock_d;
  logic [BC_W-1:0] beat_cnt_q, beat_cnt_d;

  logic            hold;
  logic            found;
  logic [ID_W-1:0] gnt;
  logic [ID_W-1:0] k_id;
  int unsigned     k;
  cplx_op_t        op;
  cplx_res_t       res;

  always_comb begin
    // Pointer is advanced on every transfer; while the lock holds the owner
    // simply overrides the search, so on release the pointer is already g+1.
    hold  = lock_q && bus.req_valid[owner_q] && (beat_cnt_q < BC_W'(BURST));
    found = 1'b0;
    gnt   = '0;
    k     = 0;
    k_id  = '0;
    if (hold) begin
      found = 1'b1;
      gnt   = owner_q;
    end else begin
      for (int unsigned i = 0; i < NREQ_U; i++) begin
        k    = (32'(ptr_q) + i) % NREQ_U;
        k_id = ID_W'(k);
        if (!found && bus.req_valid[k_id]) begin
          found = 1'b1;
          gnt   = k_id;
        end
      end
    end

    bus.req_ready = found ? (NREQ'(1) << gnt) : '0;

    op.ar = bus.req_ar[int'(gnt)*OP_W +: OP_W];
    op.ai = bus.req_ai[int'(gnt)*OP_W +: OP_W];
    op.br = bus.req_br[int'(gnt)*OP_W +: OP_W];
    op.bi = bus.req_bi[int'(gnt)*OP_W +: OP_W];

    ptr_d      = ptr_q;
    owner_d    = owner_q;
    lock_d     = lock_q;
    beat_cnt_d = beat_cnt_q;
    if (found) begin
      ptr_d = (gnt == ID_W'(NREQ - 1)) ? '0 : gnt + ID_W'(1);
      if (hold) begin
        beat_cnt_d = beat_cnt_q + BC_W'(1);
      end else begin
        owner_d    = gnt;
        lock_d     = 1'b1;
        beat_cnt_d = BC_W'(1);
      end
    end else begin
      lock_d     = 1'b0;
      beat_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      owner_q    <= '0;
      lock_q     <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      lock_q     <= lock_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  cmul_pipe #(.TAG_W(ID_W)) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (found),
    .in_tag    (gnt),
    .in_op     (op),
    .out_valid (bus.rsp_valid),
    .out_tag   (bus.rsp_id),
    .out_res   (res)
  );

  assign bus.rsp_pr = res.pr;
  assign bus.rsp_pi = res.pi;

endmodule

// File: tb/tb_cmul_rr_sched.sv
// tb_cmul_rr_sched: drives a pure round-robin instance (BURST=1) and a burst
// instance (BURST=3) side by side and compares grants and tagged results with
// a rule-level reference model.
module tb_cmul_rr_sched;
  import cmul_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cmul_rr_sched_if #(.NREQ(N)) bus_a ();
  cmul_rr_sched_if #(.NREQ(N)) bus_b ();

  cmul_rr_sched #(.NREQ(N), .BURST(1)) u_rr (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  cmul_rr_sched #(.NREQ(N), .BURST(3)) u_burst (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  typedef struct {
    int          dut;
    int          due;
    int          id;
    logic [31:0] pr;
    logic [31:0] pi;
  } exp_t;

  exp_t              expq[$];
  logic [3:0]        vld[2];
  logic signed [15:0] ar[2][4];
  logic signed [15:0] ai[2][4];
  logic signed [15:0] br[2][4];
  logic signed [15:0] bi[2][4];
  int last_g[2];
  int streak[2];
  int cyc;
  int n_chk;
  int n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic int burst_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic signed [15:0] rnd16();
    case ($urandom_range(0, 7))
      0:       return -16'sd32768;
      1:       return 16'sd32767;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [63:0] pack4(input logic signed [15:0] v0, input logic signed [15:0] v1,
                                        input logic signed [15:0] v2, input logic signed [15:0] v3);
    return {v3, v2, v1, v0};
  endfunction

  // Next grant from the rules: the current owner keeps going while valid and
  // under BURST consecutive beats; otherwise search from the one after the
  // most recently granted requester (requester 0 after reset).
  function automatic int model_grant(input int d);
    int start;
    if (streak[d] > 0 && vld[d][last_g[d]] && streak[d] < burst_of(d)) return last_g[d];
    start = (last_g[d] < 0) ? 0 : (last_g[d] + 1) % N;
    for (int i = 0; i < N; i++) begin
      if (vld[d][(start + i) % N]) return (start + i) % N;
    end
    return -1;
  endfunction

  task automatic drive();
    bus_a.req_valid = vld[0];
    bus_a.req_ar = pack4(ar[0][0], ar[0][1], ar[0][2], ar[0][3]);
    bus_a.req_ai = pack4(ai[0][0], ai[0][1], ai[0][2], ai[0][3]);
    bus_a.req_br = pack4(br[0][0], br[0][1], br[0][2], br[0][3]);
    bus_a.req_bi = pack4(bi[0][0], bi[0][1], bi[0][2], bi[0][3]);
    bus_b.req_valid = vld[1];
    bus_b.req_ar = pack4(ar[1][0], ar[1][1], ar[1][2], ar[1][3]);
    bus_b.req_ai = pack4(ai[1][0], ai[1][1], ai[1][2], ai[1][3]);
    bus_b.req_br = pack4(br[1][0], br[1][1], br[1][2], br[1][3]);
    bus_b.req_bi = pack4(bi[1][0], bi[1][1], bi[1][2], bi[1][3]);
  endtask

  task automatic new_ops(input int d, input int g);
    ar[d][g] = rnd16();
    ai[d][g] = rnd16();
    br[d][g] = rnd16();
    bi[d][g] = rnd16();
  endtask

  // One clock cycle: apply inputs, check at the falling edge, advance model.
  task automatic step();
    int          g;
    int          hit;
    int          a, b, c, e;
    logic [3:0]  obs_ready;
    logic        obs_valid;
    logic [1:0]  obs_id;
    logic [31:0] obs_pr, obs_pi;
    drive();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin
        obs_ready = bus_a.req_ready; obs_valid = bus_a.rsp_valid;
        obs_id = bus_a.rsp_id; obs_pr = bus_a.rsp_pr; obs_pi = bus_a.rsp_pi;
      end else begin
        obs_ready = bus_b.req_ready; obs_valid = bus_b.rsp_valid;
        obs_id = bus_b.rsp_id; obs_pr = bus_b.rsp_pr; obs_pi = bus_b.rsp_pi;
      end
      g = model_grant(d);
      check($sformatf("ready[%0d]", d), 32'(obs_ready), (g >= 0) ? 32'(1 << g) : 32'd0);

      hit = -1;
      foreach (expq[j]) if (hit < 0 && expq[j].dut == d && expq[j].due == cyc) hit = j;
      if (hit >= 0) begin
        check($sformatf("rsp_valid[%0d]", d), 32'(obs_valid), 32'd1);
        check($sformatf("rsp_id[%0d]", d), 32'(obs_id), 32'(expq[hit].id));
        check($sformatf("rsp_pr[%0d]", d), obs_pr, expq[hit].pr);
        check($sformatf("rsp_pi[%0d]", d), obs_pi, expq[hit].pi);
        expq.delete(hit);
      end else begin
        check($sformatf("rsp_idle[%0d]", d), 32'(obs_valid), 32'd0);
      end

      if (g >= 0) begin
        a = ar[d][g]; b = ai[d][g]; c = br[d][g]; e = bi[d][g];
        expq.push_back('{dut: d, due: cyc + PIPE_LAT, id: g,
                         pr: 32'(a * c - b * e), pi: 32'(a * e + b * c)});
        if (streak[d] > 0 && last_g[d] == g && streak[d] < burst_of(d)) streak[d]++;
        else streak[d] = 1;
        last_g[d] = g;
        new_ops(d, g);
      end else begin
        streak[d] = 0;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive();
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    expq.delete();
    for (int d = 0; d < 2; d++) begin
      last_g[d] = -1;
      streak[d] = 0;
    end
    check("rst_valid_a", 32'(bus_a.rsp_valid), 32'd0);
    check("rst_id_a", 32'(bus_a.rsp_id), 32'd0);
    check("rst_pr_a", bus_a.rsp_pr, 32'd0);
    check("rst_pi_a", bus_a.rsp_pi, 32'd0);
    check("rst_valid_b", 32'(bus_b.rsp_valid), 32'd0);
    check("rst_pr_b", bus_b.rsp_pr, 32'd0);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    cyc = 0;
    for (int d = 0; d < 2; d++) begin
      vld[d] = '0;
      for (int i = 0; i < N; i++) new_ops(d, i);
    end
    do_reset();

    // Idle, then a lone request from 0.
    for (int i = 0; i < 10; i++) step();
    vld[0] = 4'b0001; vld[1] = 4'b0001;
    step();
    vld[0] = '0; vld[1] = '0;
    for (int i = 0; i < 3; i++) step();

    // Single request from 2 with the documented operands.
    for (int d = 0; d < 2; d++) begin
      ar[d][2] = 16'sd3; ai[d][2] = 16'sd4; br[d][2] = 16'sd5; bi[d][2] = -16'sd2;
    end
    vld[0] = 4'b0100; vld[1] = 4'b0100;
    step();
    vld[0] = '0; vld[1] = '0;
    for (int i = 0; i < 3; i++) step();

    // Most-negative operands: products wrap in the sum.
    for (int d = 0; d < 2; d++) begin
      ar[d][1] = -16'sd32768; ai[d][1] = -16'sd32768;
      br[d][1] = -16'sd32768; bi[d][1] = -16'sd32768;
    end
    vld[0] = 4'b0010; vld[1] = 4'b0010;
    step();
    vld[0] = '0; vld[1] = '0;
    for (int i = 0; i < 3; i++) step();

    // All requesters continuously valid.
    vld[0] = 4'b1111; vld[1] = 4'b1111;
    for (int i = 0; i < 14; i++) step();

    // Burst between 1 and 3 from a fresh pointer, then 1 drops after one beat.
    do_reset();
    vld[0] = 4'b1010; vld[1] = 4'b1010;
    for (int i = 0; i < 7; i++) step();
    vld[0] = 4'b1000; vld[1] = 4'b1000;
    for (int i = 0; i < 3; i++) step();

    // Reset with results in flight, all requesters still valid.
    vld[0] = 4'b1111; vld[1] = 4'b1111;
    for (int i = 0; i < 3; i++) step();
    do_reset();
    for (int i = 0; i < 4; i++) step();

    // Random traffic with sticky valids so bursts and drops both occur.
    for (int t = 0; t < 400; t++) begin
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < N; i++)
          if ($urandom_range(0, 3) == 0) vld[d][i] = ~vld[d][i];
      step();
    end

    vld[0] = '0; vld[1] = '0;
    for (int i = 0; i < 4; i++) step();
    check("drain_outstanding", 32'(expq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
